// File: rtl/debug_module_mh.sv
// Multi-hart RISC-V external debug module (0.13 subset).
// Sits between the DTM's DMI bus and NHARTS hart cores. Tracks per-hart halt/resume/havereset
// state through hartsel, holds NDATA abstract data registers with autoexec, and runs Access
// Register commands on the selected hart over a valid/ready access bus.
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   dmi_req_*                   DMI request (valid, addr, data, op: 01 read / 10 write)
//   dmi_rsp_data/dmi_rsp_valid  registered DMI response, one cycle after the request
//   hart_halted/haltreq/resumereq  per-hart run control
//   ndmreset                    system reset request
//   acc_*                       abstract register access bus to the harts
module debug_module_mh #(
  parameter int unsigned NHARTS = 2,
  parameter int unsigned NDATA  = 2,
  localparam int unsigned HW    = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmi_req_valid,
  input  logic [6:0]        dmi_req_addr,
  input  logic [31:0]       dmi_req_data,
  input  logic [1:0]        dmi_req_op,
  output logic [31:0]       dmi_rsp_data,
  output logic              dmi_rsp_valid,
  input  logic [NHARTS-1:0] hart_halted,
  output logic [NHARTS-1:0] hart_haltreq,
  output logic [NHARTS-1:0] hart_resumereq,
  output logic              ndmreset,
  output logic [HW-1:0]     acc_hart,
  output logic [15:0]       acc_addr,
  output logic [31:0]       acc_wdata,
  input  logic [31:0]       acc_rdata,
  output logic              acc_rd,
  output logic              acc_wr,
  output logic              acc_valid,
  input  logic              acc_ready
);

  localparam logic [6:0] AddrData0    = 7'h04;
  localparam logic [6:0] AddrDmcontrol = 7'h10;
  localparam logic [6:0] AddrDmstatus = 7'h11;
  localparam logic [6:0] AddrAbstractcs = 7'h16;
  localparam logic [6:0] AddrCommand  = 7'h17;
  localparam logic [6:0] AddrAbstractauto = 7'h18;

  typedef enum logic [1:0] {StIdle, StCheck, StExec, StWait} state_e;

  state_e              state_q, state_d;
  logic                dmactive_q, ndmreset_q, ndmreset_d;
  logic [HW-1:0]       hartsel_q, hartsel_d, acc_hart_q, acc_hart_d;
  logic [NHARTS-1:0]   haltreq_q, haltreq_d, resumereq_q, resumereq_d;
  logic [NHARTS-1:0]   resumeack_q, resumeack_d, havereset_q, havereset_d;
  logic [31:0]         data_q [NDATA];
  logic [31:0]         data_d [NDATA];
  logic [NDATA-1:0]    autoexec_q, autoexec_d;
  logic [2:0]          cmderr_q, cmderr_d;
  logic [31:0]         cmd_q, cmd_d;
  logic [31:0]         rsp_data_q, rd_val;
  logic                rsp_valid_q;

  logic rst_dm, req_wr, req_rd, dmc_wr, busy, data_any, busy_err, trigger;
  logic [NDATA-1:0] data_sel;
  logic [2:0] fsm_err, err;
  logic sel_exists, sel_halted, sel_havereset, sel_resumeack, tgt_exists, tgt_halted;

  assign rst_dm = rst | ~dmactive_q;
  assign req_wr = dmi_req_valid & (dmi_req_op == 2'b10);
  assign req_rd = dmi_req_valid & (dmi_req_op == 2'b01);
  assign dmc_wr = req_wr & (dmi_req_addr == AddrDmcontrol);
  assign busy   = (state_q != StIdle);

  // Per-hart status of the DMI-selected hart and of the latched command target.
  always_comb begin
    sel_exists = 1'b0; sel_halted = 1'b0; sel_havereset = 1'b0; sel_resumeack = 1'b0;
    tgt_exists = 1'b0; tgt_halted = 1'b0;
    for (int i = 0; i < NHARTS; i++) begin
      if (hartsel_q == HW'(i)) begin
        sel_exists    = 1'b1;
        sel_halted    = hart_halted[i];
        sel_havereset = havereset_q[i];
        sel_resumeack = resumeack_q[i];
      end
      if (acc_hart_q == HW'(i)) begin
        tgt_exists = 1'b1;
        tgt_halted = hart_halted[i];
      end
    end
  end

  always_comb begin
    data_sel = '0;
    for (int k = 0; k < NDATA; k++) data_sel[k] = (dmi_req_addr == AddrData0 + 7'(k));
  end
  assign data_any = |data_sel;

  // Read mux; everything reads 0 while the module is held in reset by dmactive.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NDATA; k++) if (data_sel[k]) rd_val = data_q[k];
    case (dmi_req_addr)
      AddrDmcontrol: begin
        rd_val[16 +: HW] = hartsel_q;
        rd_val[1]        = ndmreset_q;
        rd_val[0]        = dmactive_q;
      end
      AddrDmstatus: begin
        rd_val[19:18] = {2{sel_havereset}};
        rd_val[17:16] = {2{sel_resumeack}};
        rd_val[15:14] = {2{~sel_exists}};
        rd_val[13:12] = {2{ndmreset_q}};
        rd_val[11:10] = {2{sel_exists & ~sel_halted}};
        rd_val[9:8]   = {2{sel_exists & sel_halted}};
        rd_val[7]     = 1'b1;
        rd_val[3:0]   = 4'd2;
      end
      AddrAbstractcs: begin
        rd_val[12]   = busy;
        rd_val[10:8] = cmderr_q;
        rd_val[3:0]  = 4'(NDATA);
      end
      AddrCommand:      rd_val = cmd_q;
      AddrAbstractauto: rd_val[NDATA-1:0] = autoexec_q;
      default: ;
    endcase
    if (rst_dm) rd_val = '0;
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    acc_hart_d  = acc_hart_q;
    ndmreset_d  = ndmreset_q;
    hartsel_d   = hartsel_q;
    haltreq_d   = haltreq_q & ~hart_halted;
    resumereq_d = resumereq_q & hart_halted;
    resumeack_d = resumeack_q | (resumereq_q & ~hart_halted);
    havereset_d = havereset_q;
    autoexec_d  = autoexec_q;
    data_d      = data_q;
    cmderr_d    = cmderr_q;
    busy_err    = 1'b0;
    fsm_err     = 3'd0;
    trigger     = 1'b0;

    if (dmc_wr) begin
      hartsel_d  = dmi_req_data[16 +: HW];
      ndmreset_d = dmi_req_data[1];
    end
    if (ndmreset_q & ~ndmreset_d) havereset_d = '1;
    if (dmc_wr) begin
      for (int i = 0; i < NHARTS; i++) begin
        if (dmi_req_data[16 +: HW] == HW'(i)) begin
          if (dmi_req_data[31]) begin
            haltreq_d[i] = 1'b1;
          end else if (dmi_req_data[30]) begin
            resumereq_d[i] = 1'b1;
            resumeack_d[i] = 1'b0;
          end
          if (dmi_req_data[28]) havereset_d[i] = 1'b0;
        end
      end
    end

    if (busy) begin
      // Accesses that would disturb a running command are dropped and flagged.
      if ((req_wr && (dmi_req_addr == AddrCommand || dmi_req_addr == AddrAbstractcs ||
                      dmi_req_addr == AddrAbstractauto || data_any)) || (req_rd && data_any)) begin
        busy_err = 1'b1;
      end
    end else begin
      if (req_wr && dmi_req_addr == AddrAbstractcs) cmderr_d = cmderr_q & ~dmi_req_data[10:8];
      if (req_wr && dmi_req_addr == AddrAbstractauto) autoexec_d = dmi_req_data[NDATA-1:0];
      for (int k = 0; k < NDATA; k++) if (req_wr && data_sel[k]) data_d[k] = dmi_req_data;
      if (cmderr_q == 3'd0) begin
        if (req_wr && dmi_req_addr == AddrCommand) begin
          trigger    = 1'b1;
          cmd_d      = dmi_req_data;
          acc_hart_d = hartsel_q;
        end
        for (int k = 0; k < NDATA; k++)
          if ((req_wr || req_rd) && data_sel[k] && autoexec_q[k]) trigger = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: if (trigger) state_d = StCheck;
      StCheck: begin
        state_d = StIdle;
        if (cmd_q[31:24] != 8'd0 || cmd_q[22:20] != 3'd2 || cmd_q[18]) begin
          fsm_err = 3'd2;
        end else if (cmd_q[17] && (!tgt_halted || !tgt_exists || ndmreset_q)) begin
          fsm_err = 3'd4;
        end else if (!cmd_q[17]) begin
          if (cmd_q[19]) cmd_d[15:0] = cmd_q[15:0] + 16'd1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: state_d = StWait;
      StWait: begin
        if (acc_ready) begin
          if (!cmd_q[16]) data_d[0] = acc_rdata;
          if (cmd_q[19]) cmd_d[15:0] = cmd_q[15:0] + 16'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    err = (fsm_err != 3'd0) ? fsm_err : (busy_err ? 3'd1 : 3'd0);
    if (err != 3'd0 && cmderr_q == 3'd0) cmderr_d = err;
  end

  // dmactive and the DMI response path live outside rst_dm so the bus keeps answering.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmactive_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      if (dmc_wr) dmactive_q <= dmi_req_data[0];
      rsp_valid_q <= dmi_req_valid;
      rsp_data_q  <= req_rd ? rd_val : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_dm) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      acc_hart_q  <= '0;
      ndmreset_q  <= 1'b0;
      hartsel_q   <= '0;
      haltreq_q   <= '0;
      resumereq_q <= '0;
      resumeack_q <= '0;
      havereset_q <= '0;
      autoexec_q  <= '0;
      cmderr_q    <= '0;
      for (int k = 0; k < NDATA; k++) data_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      acc_hart_q  <= acc_hart_d;
      ndmreset_q  <= ndmreset_d;
      hartsel_q   <= hartsel_d;
      haltreq_q   <= haltreq_d;
      resumereq_q <= resumereq_d;
      resumeack_q <= resumeack_d;
      havereset_q <= havereset_d;
      autoexec_q  <= autoexec_d;
      cmderr_q    <= cmderr_d;
      for (int k = 0; k < NDATA; k++) data_q[k] <= data_d[k];
    end
  end

  assign dmi_rsp_data   = rsp_data_q;
  assign dmi_rsp_valid  = rsp_valid_q;
  assign hart_haltreq   = haltreq_q;
  assign hart_resumereq = resumereq_q;
  assign ndmreset       = ndmreset_q;
  assign acc_hart       = acc_hart_q;
  assign acc_addr       = cmd_q[15:0];
  assign acc_wdata      = data_q[0];
  assign acc_valid      = (state_q == StExec);
  assign acc_rd = (state_q == StExec || state_q == StWait) & cmd_q[17] & ~cmd_q[16];
  assign acc_wr = (state_q == StExec || state_q == StWait) & cmd_q[17] & cmd_q[16];

endmodule
